// File: rtl/mux_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mux_uart_tx
// Description : Memory-mapped 8N1 UART transmitter with a two-byte register
//               window (STATUS at BASE_ADDR+0, DATA at BASE_ADDR+1), a
//               transmit FIFO and a registered serial output.
//               Build macro MUX_UART_TX_FIFO_EN selects a 4-entry FIFO;
//               without it a single holding register is used.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_uart_tx #(
    parameter logic [15:0] BASE_ADDR    = 16'hF200,
    parameter int          CLKS_PER_BIT = 104
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        tx
);

`ifdef MUX_UART_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int MEM_N = 1 << PTR_W;

    localparam logic [CNT_W-1:0] C_DEPTH       = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_LAST    = PTR_W'(DEPTH - 1);
    localparam logic [15:0]      C_BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0]      C_DATA_ADDR   = BASE_ADDR + 16'd1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       r_state;
    logic [15:0]      r_baud;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic [7:0]       r_data_out;
    logic             r_overrun;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [7:0]       r_mem [MEM_N];

    logic [1:0]  w_state_next;
    logic [15:0] w_baud_next;
    logic [2:0]  w_idx_next;
    logic [2:0]  w_idx_inc;
    logic        w_tx_next;
    logic        w_pop;
    logic        w_wr_data;
    logic        w_accept;
    logic        w_overrun_set;
    logic        w_status_rd;
    logic        w_ready;
    logic        w_busy;
    logic [7:0]  w_status;

    // Bus decode, FIFO admission and STATUS composition.
    assign w_wr_data     = write_en && (address == C_DATA_ADDR);
    assign w_status_rd   = !write_en && (address == BASE_ADDR);
    assign w_ready       = (r_count != C_DEPTH);
    // A full FIFO still admits a byte when the head leaves in the same cycle.
    assign w_accept      = w_wr_data && (w_ready || w_pop);
    assign w_overrun_set = w_wr_data && !w_accept;
    assign w_busy        = (r_state != S_IDLE) || (r_count != '0);
    assign w_status      = {4'b0000, w_busy, r_overrun, w_ready, 1'b0};
    assign w_idx_inc     = r_idx + 3'd1;

    assign data_out = r_data_out;
    assign tx       = r_tx;

    // Shifter next-state, baud reload and next serial level.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = (r_baud != 16'd0) ? (r_baud - 16'd1) : r_baud;
        w_idx_next   = r_idx;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_next = 1'b1;
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                    w_baud_next  = C_BAUD_RELOAD;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (r_baud == 16'd0) begin
                    w_state_next = S_DATA;
                    w_baud_next  = C_BAUD_RELOAD;
                    w_idx_next   = 3'd0;
                    w_tx_next    = r_shift[0];
                end
            end
            S_DATA: begin
                if (r_baud == 16'd0) begin
                    w_baud_next = C_BAUD_RELOAD;
                    if (r_idx == 3'd7) begin
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_idx_next = w_idx_inc;
                        w_tx_next  = r_shift[w_idx_inc];
                    end
                end
            end
            S_STOP: begin
                if (r_baud == 16'd0) begin
                    w_state_next = S_IDLE;
                    w_baud_next  = C_BAUD_RELOAD;
                    w_tx_next    = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // Shifter state, counters, serial output and shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= 16'd0;
            r_idx   <= 3'd0;
            r_tx    <= 1'b1;
            r_shift <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_idx   <= w_idx_next;
            r_tx    <= w_tx_next;
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end
        end
    end

    // FIFO pointers/count, sticky overrun and registered read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overrun  <= 1'b0;
            r_data_out <= 8'h00;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : (r_wr_ptr + 1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : (r_rd_ptr + 1'b1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            // A fresh overrun wins over the clear-on-read of the old flag.
            r_overrun  <= w_overrun_set || (r_overrun && !w_status_rd);
            r_data_out <= w_status_rd ? w_status : 8'h00;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (w_accept && !reset) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_uart_tx
// Description : Self-checking bench for mux_uart_tx: register-access vector
//               table, directed frame/overrun/reset sequences and random
//               bus traffic against a frame-timing reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_uart_tx;

    localparam int          CPB  = 4;
    localparam logic [15:0] BASE = 16'hF200;
`ifdef MUX_UART_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic [15:0] address  = 16'h0000;
    logic        write_en = 1'b0;
    logic [7:0]  data_in  = 8'h00;
    logic [7:0]  data_out;
    logic        tx;

    mux_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .write_en(write_en),
        .data_in (data_in),
        .data_out(data_out),
        .tx      (tx)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: queue of accepted bytes plus elapsed time in the frame.
    logic [7:0] m_q[$];
    bit         m_active  = 1'b0;
    int         m_elapsed = 0;
    logic [7:0] m_cur     = 8'h00;
    bit         m_ovr     = 1'b0;
    logic [7:0] m_dout    = 8'h00;
    logic       m_tx      = 1'b1;

    typedef struct {
        logic        rst;
        logic [15:0] addr;
        logic        we;
        logic [7:0]  din;
        logic [7:0]  exp_dout;
        logic        exp_tx;
    } vec_t;
    vec_t tbl[9];

    function automatic logic frame_bit(input logic [7:0] b, input int e);
        if (e < CPB) return 1'b0;
        if (e < 9 * CPB) return b[e / CPB - 1];
        return 1'b1;
    endfunction

    task automatic model_step();
        bit         pop, rd, wr, newovr;
        logic [7:0] status;
        if (reset) begin
            m_q.delete();
            m_active  = 1'b0;
            m_elapsed = 0;
            m_ovr     = 1'b0;
            m_dout    = 8'h00;
            m_tx      = 1'b1;
            return;
        end
        pop    = !m_active && (m_q.size() > 0);
        rd     = !write_en && (address == BASE);
        wr     = write_en && (address == BASE + 16'd1);
        status = {4'b0000, (m_active || m_q.size() > 0), m_ovr,
                  (m_q.size() < DEPTH), 1'b0};
        m_dout = rd ? status : 8'h00;
        newovr = 1'b0;
        if (pop) m_cur = m_q.pop_front();
        if (wr) begin
            if (m_q.size() < DEPTH) m_q.push_back(data_in);
            else newovr = 1'b1;
        end
        m_ovr = newovr || (m_ovr && !rd);
        if (m_active) begin
            m_elapsed++;
            if (m_elapsed == 10 * CPB) m_active = 1'b0;
        end
        if (pop) begin
            m_active  = 1'b1;
            m_elapsed = 0;
        end
        m_tx = m_active ? frame_bit(m_cur, m_elapsed) : 1'b1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    task automatic drive(input logic r, input logic [15:0] a, input logic w, input logic [7:0] d);
        reset    = r;
        address  = a;
        write_en = w;
        data_in  = d;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        check("model_tx", {7'd0, tx}, {7'd0, m_tx});
        check("model_dout", data_out, m_dout);
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        drive(1'b0, 16'h0000, 1'b0, 8'h00);
        while ((m_active || m_q.size() > 0) && guard < (DEPTH + 3) * 10 * CPB) begin
            tick();
            guard++;
        end
        if (m_active || m_q.size() > 0) timeout_fail(name);
        tick();
    endtask

    logic [9:0] sym;

    initial begin
        int guard;

        tbl[0] = '{1'b1, 16'hF200, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[1] = '{1'b1, 16'hF201, 1'b1, 8'hFF, 8'h00, 1'b1};
        tbl[2] = '{1'b0, 16'hF200, 1'b0, 8'h00, 8'h02, 1'b1};
        tbl[3] = '{1'b0, 16'hF201, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[4] = '{1'b0, 16'hF202, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[5] = '{1'b0, 16'hF1FF, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[6] = '{1'b0, 16'hF200, 1'b1, 8'hFF, 8'h00, 1'b1};
        tbl[7] = '{1'b0, 16'hF200, 1'b0, 8'h00, 8'h02, 1'b1};
        tbl[8] = '{1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b1};

        // Register access vectors from reset.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].rst, tbl[i].addr, tbl[i].we, tbl[i].din);
            tick();
            check($sformatf("tbl%0d_dout", i), data_out, tbl[i].exp_dout);
            check($sformatf("tbl%0d_tx", i), {7'd0, tx}, {7'd0, tbl[i].exp_tx});
        end

        // Single A5 frame: one idle cycle, then 10 symbols of CPB cycles.
        drive(1'b0, 16'hF201, 1'b1, 8'hA5);
        tick();
        check("a5_idle_cycle", {7'd0, tx}, 8'd1);
        drive(1'b0, 16'hF200, 1'b0, 8'h00);
        sym = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10 * CPB; i++) begin
            tick();
            check($sformatf("a5_tx_c%0d", i), {7'd0, tx}, {7'd0, sym[i / CPB]});
            if (i >= 1) check("a5_status_busy", data_out, 8'h0A);
        end
        tick();
        tick();
        check("a5_status_done", data_out, 8'h02);
        check("a5_tx_done", {7'd0, tx}, 8'd1);

        // Overrun from a burst of writes one beyond the capacity.
`ifdef MUX_UART_TX_FIFO_EN
        for (int i = 1; i <= 6; i++) begin
            drive(1'b0, 16'hF201, 1'b1, 8'(i));
            tick();
        end
`else
        drive(1'b0, 16'hF201, 1'b1, 8'h55); tick();
        drive(1'b0, 16'hF201, 1'b1, 8'hAA); tick();
        drive(1'b0, 16'hF201, 1'b1, 8'h33); tick();
`endif
        drive(1'b0, 16'hF200, 1'b0, 8'h00);
        tick();
        check("ovr_status_set", data_out, 8'h0C);
        tick();
        check("ovr_status_cleared", data_out, 8'h08);
        drain("ovr_drain");
        drive(1'b0, 16'hF200, 1'b0, 8'h00);
        tick();
        check("ovr_status_idle", data_out, 8'h02);

        // Full FIFO with a write landing on the pop cycle.
        drive(1'b0, 16'hF201, 1'b1, 8'h10);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 16'hF201, 1'b1, 8'h20 + 8'(i));
            tick();
        end
        drive(1'b0, 16'h0000, 1'b0, 8'h00);
        guard = 0;
        while (!(!m_active && m_q.size() == DEPTH) && guard < 20 * CPB) begin
            tick();
            guard++;
        end
        if (!(!m_active && m_q.size() == DEPTH)) timeout_fail("popwr_wait");
        drive(1'b0, 16'hF201, 1'b1, 8'hC3);
        tick();
        drive(1'b0, 16'hF200, 1'b0, 8'h00);
        tick();
        check("popwr_status", data_out, 8'h08);
        drain("popwr_drain");
        drive(1'b0, 16'hF200, 1'b0, 8'h00);
        tick();
        check("popwr_no_overrun", data_out, 8'h02);

        // Reset during data bit 3 with a second byte queued.
        drive(1'b0, 16'hF201, 1'b1, 8'h52); tick();
        drive(1'b0, 16'hF201, 1'b1, 8'h77); tick();
        drive(1'b0, 16'h0000, 1'b0, 8'h00);
        for (int i = 0; i < 4 * CPB + 1; i++) tick();
        check("rst_bit3_level", {7'd0, tx}, 8'd0);
        drive(1'b1, 16'h0000, 1'b0, 8'h00);
        tick();
        check("rst_tx_high", {7'd0, tx}, 8'd1);
        drive(1'b0, 16'hF200, 1'b0, 8'h00);
        tick();
        check("rst_status", data_out, 8'h02);
        drive(1'b0, 16'h0000, 1'b0, 8'h00);
        for (int i = 0; i < 12 * CPB; i++) begin
            tick();
            check("rst_no_start", {7'd0, tx}, 8'd1);
        end

        // Random bus traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            case ($urandom_range(0, 3))
                0: a = BASE;
                1: a = BASE + 16'd1;
                2: a = BASE + 16'd2;
                default: a = 16'($urandom);
            endcase
            drive(($urandom_range(0, 299) == 0), a,
                  ($urandom_range(0, 99) < 12), 8'($urandom));
            tick();
        end
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mux_uart_tx.md
MUX_UART_TX -- requirements
Module: mux_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 16'hF200, is the 16-bit base of the two-byte register window.
REQ-002 Parameter CLKS_PER_BIT, default 104, is the number of clock cycles per serial bit; legal range is 2..65535.
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port address, input, 16 bits: CPU address bus.
REQ-006 Port write_en, input, 1 bit: CPU write strobe, sampled once per clock.
REQ-007 Port data_in, input, 8 bits: CPU-to-peripheral data bus.
REQ-008 Port data_out, output, 8 bits: peripheral-to-CPU read data, registered.
REQ-009 Port tx, output, 1 bit: serial line, idle high.

Function
REQ-010 Register map: BASE_ADDR+0 is STATUS (read); BASE_ADDR+1 is DATA (write-only, reads return 8'h00); other addresses are not selected.
REQ-011 STATUS layout: bit1 = tx_ready (FIFO not full); bit2 = overrun (sticky); bit3 = busy (shifter not IDLE or FIFO not empty); all other bits 0.
REQ-012 data_out updates one cycle after address is presented: STATUS contents when the previous-cycle address was BASE_ADDR+0 with write_en=0, otherwise 8'h00, so the top level can OR it with other peripherals.
REQ-013 A write to DATA enqueues data_in when count<DEPTH, or when count==DEPTH and the shifter pops in the same cycle.
REQ-014 A write to DATA under any other condition discards the byte and sets overrun.
REQ-015 overrun clears on the cycle after a STATUS read; when a new overrun occurs in that same cycle, overrun stays set.
REQ-016 Writes to STATUS have no effect.
REQ-017 The FIFO is first-in-first-out, with circular read and write pointers that wrap modulo DEPTH and a count from 0 to DEPTH.
REQ-018 Shifter states are IDLE, START, DATA and STOP.
REQ-019 In IDLE, tx=1; when count>0, the shifter pops the head byte into the shift register and enters START on the next edge.
REQ-020 START drives tx=0 for CLKS_PER_BIT cycles, then enters DATA.
REQ-021 DATA drives 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit index; after bit 7 it enters STOP.
REQ-022 STOP drives tx=1 for CLKS_PER_BIT cycles, then enters IDLE.
REQ-023 A frame is exactly 10*CLKS_PER_BIT cycles, 8N1.
REQ-024 Back-to-back frames have exactly one idle cycle (tx=1) between the STOP end and the next START.
REQ-025 The baud counter reloads to CLKS_PER_BIT-1 on every state entry, decrements to 0, and the state advances when it reaches 0.
REQ-026 tx is driven from a flip-flop with no combinational path from any input.

Reset
REQ-027 While reset=1 at an edge: state=IDLE, tx=1, data_out=8'h00, count=0, pointers=0, overrun=0, baud counter=0, bit index=0.
REQ-028 Reset asserted mid-frame aborts the frame immediately, with tx=1 on the following cycle, and discards all queued bytes.
REQ-029 Writes presented while reset=1 are ignored.
REQ-030 After reset deasserts, the first STATUS read returns 8'h02.

Configuration
REQ-031 Macro MUX_UART_TX_FIFO_EN defined: DEPTH=4, a 4-entry FIFO.
REQ-032 Macro MUX_UART_TX_FIFO_EN undefined: DEPTH=1, a single holding register; all full, overrun and pop rules apply unchanged with DEPTH=1.

Verification
REQ-033 Reset, then read STATUS -> data_out=8'h02 one cycle later, and tx=1 continuously.
REQ-034 CLKS_PER_BIT=4, write 8'hA5 to F201 -> after 1 idle cycle tx=0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; 40 cycles total.
REQ-035 FIFO_EN defined, CLKS_PER_BIT=4: write 8'h01 through 8'h06 in consecutive cycles -> bytes 01..05 are sent (1 popped plus 4 queued), 06 is dropped, STATUS=8'h0C (overrun, busy; tx_ready clear).
REQ-036 FIFO_EN undefined: write 8'h55 then 8'hAA in consecutive cycles -> 55 moves to the shifter and AA is accepted into the holding register; a third write while holding is full and no pop occurs -> overrun=1.
REQ-037 Mid-frame reset during DATA bit 3 -> tx=1 on the next cycle, STATUS=8'h02 after release, and no further start bit.
REQ-038 With the FIFO full, a write coincident with the pop cycle -> byte accepted, overrun stays 0, all bytes are transmitted in order.
